// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states and default bus widths.
package cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    localparam logic [3:0] OPC_ADD = 4'b0000;
    localparam logic [3:0] OPC_MVI = 4'b0001;
    localparam logic [3:0] OPC_LDA = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_O = 2'd2,
        ST_HOLD   = 2'd3
    } fetch_state_t;

    // Opcodes that are followed by an immediate word in program memory.
    function automatic logic is_two_word(input logic [3:0] opcode);
        return (opcode == OPC_MVI) || (opcode == OPC_LDA);
    endfunction

endpackage

// File: rtl/mem_fetch_if.sv
// Controller/RAM/decoder-facing signals of the instruction fetcher.
interface mem_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              ld_pc;
    logic [ADDR_W-1:0] pc_in;
    logic              ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] operand;
    logic              two_word;
    logic              valid;
    logic              busy;
    logic [ADDR_W-1:0] pc;

    // Environment side: controller, RAM data and decoder acknowledge.
    modport master (
        output req, ld_pc, pc_in, ack, mem_data,
        input  mem_addr, instr, operand, two_word, valid, busy, pc
    );

    // Fetcher side.
    modport slave (
        input  req, ld_pc, pc_in, ack, mem_data,
        output mem_addr, instr, operand, two_word, valid, busy, pc
    );
endinterface

// File: rtl/mem_fetch_pc_reg.sv
// Program counter with jump load (priority) and wrapping increment.
module pc_reg #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/mem_fetch.sv
// Instruction fetcher: launches RAM reads from the PC, waits the read latency,
// gathers one- or two-word instructions and holds them for the decoder.
module mem_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_fetch_if.slave   bus
);

    localparam int               CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_next;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_instr_next;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] w_operand_next;
    logic              r_two_word;
    logic              w_two_word_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_busy;
    logic              w_busy_next;

    logic              w_pc_load;
    logic              w_pc_inc;
    logic [ADDR_W-1:0] w_pc;
    logic              w_cnt_done;
    logic              w_data_two_word;

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (bus.pc_in),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    assign w_cnt_done      = (r_cnt == CNT_LAST);
    assign w_data_two_word = is_two_word(bus.mem_data[DATA_W-1 -: 4]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_instr    <= '0;
            r_operand  <= '0;
            r_two_word <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_mem_addr <= w_mem_addr_next;
            r_instr    <= w_instr_next;
            r_operand  <= w_operand_next;
            r_two_word <= w_two_word_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_mem_addr_next = r_mem_addr;
        w_instr_next    = r_instr;
        w_operand_next  = r_operand;
        w_two_word_next = r_two_word;
        w_valid_next    = r_valid;
        w_pc_load       = 1'b0;
        w_pc_inc        = 1'b0;

        if (bus.ld_pc) begin
            // Jump wins over everything; data still in the RAM pipeline is dropped.
            w_pc_load    = 1'b1;
            w_valid_next = 1'b0;
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        w_mem_addr_next = w_pc;
                        w_pc_inc        = 1'b1;
                        w_cnt_next      = '0;
                        w_state_next    = ST_WAIT_I;
                    end
                end
                ST_WAIT_I: begin
                    if (w_cnt_done) begin
                        w_cnt_next   = '0;
                        w_instr_next = bus.mem_data;
                        if (w_data_two_word) begin
                            // Immediate word launched on the same edge as the capture.
                            w_two_word_next = 1'b1;
                            w_mem_addr_next = w_pc;
                            w_pc_inc        = 1'b1;
                            w_state_next    = ST_WAIT_O;
                        end else begin
                            w_two_word_next = 1'b0;
                            w_operand_next  = '0;
                            w_valid_next    = 1'b1;
                            w_state_next    = ST_HOLD;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_O: begin
                    if (w_cnt_done) begin
                        w_cnt_next     = '0;
                        w_operand_next = bus.mem_data;
                        w_valid_next   = 1'b1;
                        w_state_next   = ST_HOLD;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.ack) begin
                        w_valid_next = 1'b0;
                        if (bus.req) begin
                            w_mem_addr_next = w_pc;
                            w_pc_inc        = 1'b1;
                            w_cnt_next      = '0;
                            w_state_next    = ST_WAIT_I;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy_next = (w_state_next == ST_WAIT_I) || (w_state_next == ST_WAIT_O);

    assign bus.mem_addr = r_mem_addr;
    assign bus.instr    = r_instr;
    assign bus.operand  = r_operand;
    assign bus.two_word = r_two_word;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.pc       = w_pc;

endmodule

// File: tb/tb_mem_fetch.sv
// Directed bench for mem_fetch with a registered-read RAM model (RD_LAT = 2).
module tb_mem_fetch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bit [15:0] ram [0:65535];

    mem_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_fetch #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_LAT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: address sampled on the edge, data registered on the same edge.
    always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"},       bus.pc,       0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_instr"},    bus.instr,    0);
        chk({tag, "_operand"},  bus.operand,  0);
        chk({tag, "_two_word"}, bus.two_word, 0);
        chk({tag, "_valid"},    bus.valid,    0);
        chk({tag, "_busy"},     bus.busy,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.req = 0; bus.ld_pc = 0; bus.pc_in = '0; bus.ack = 0; bus.mem_data = '0;
        ram[16'h0000] = 16'h0123;   // ADD
        ram[16'h0001] = 16'h1A00;   // MVI
        ram[16'h0002] = 16'h1388;
        ram[16'h0003] = 16'h0777;
        ram[16'h85A1] = 16'h3C5A;   // one-word opcode 3
        ram[16'hFFFF] = 16'h2042;   // LDA
        rst = 0;
        #1 rst = 1;
        #2;
        $display("reset asserted");
        chk_all_zero("reset");
        tick();
        rst = 0;

        // One-word ADD from address 0
        bus.req = 1;
        tick();
        $display("ADD launch: mem_addr=%h pc=%h busy=%b", bus.mem_addr, bus.pc, bus.busy);
        chk("add_mem_addr", bus.mem_addr, 16'h0000);
        chk("add_pc_launch", bus.pc, 16'h0001);
        chk("add_busy", bus.busy, 1);
        bus.req = 0;
        tick();
        chk("add_valid_e1", bus.valid, 0);
        tick();
        $display("ADD done: instr=%h operand=%h two_word=%b valid=%b", bus.instr, bus.operand, bus.two_word, bus.valid);
        chk("add_valid_e2", bus.valid, 1);
        chk("add_instr", bus.instr, 16'h0123);
        chk("add_operand", bus.operand, 16'h0000);
        chk("add_two_word", bus.two_word, 0);
        chk("add_pc", bus.pc, 16'h0001);
        chk("add_busy_hold", bus.busy, 0);

        // Hold with ack low: everything frozen
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("hold cycle %0d: valid=%b instr=%h", i, bus.valid, bus.instr);
            chk("hold_valid", bus.valid, 1);
            chk("hold_instr", bus.instr, 16'h0123);
            chk("hold_mem_addr", bus.mem_addr, 16'h0000);
        end

        // ack + req together: next launch on the ack edge (MVI at 1)
        bus.ack = 1; bus.req = 1;
        tick();
        bus.ack = 0; bus.req = 0;
        $display("b2b launch: mem_addr=%h valid=%b busy=%b", bus.mem_addr, bus.valid, bus.busy);
        chk("b2b_valid", bus.valid, 0);
        chk("b2b_mem_addr", bus.mem_addr, 16'h0001);
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_pc", bus.pc, 16'h0002);
        tick();
        chk("mvi_valid_e1", bus.valid, 0);
        tick();
        $display("MVI word0: instr=%h mem_addr=%h pc=%h", bus.instr, bus.mem_addr, bus.pc);
        chk("mvi_instr", bus.instr, 16'h1A00);
        chk("mvi_addr1", bus.mem_addr, 16'h0002);
        chk("mvi_valid_e2", bus.valid, 0);
        chk("mvi_busy_e2", bus.busy, 1);
        tick();
        chk("mvi_valid_e3", bus.valid, 0);
        tick();
        $display("MVI done: operand=%h two_word=%b valid=%b pc=%h", bus.operand, bus.two_word, bus.valid, bus.pc);
        chk("mvi_valid_e4", bus.valid, 1);
        chk("mvi_operand", bus.operand, 16'h1388);
        chk("mvi_two_word", bus.two_word, 1);
        chk("mvi_pc", bus.pc, 16'h0003);

        bus.ack = 1;
        tick();
        bus.ack = 0;
        $display("ack alone: valid=%b busy=%b", bus.valid, bus.busy);
        chk("ack_valid", bus.valid, 0);
        chk("ack_busy", bus.busy, 0);

        // Jump during WAIT_I discards the in-flight word; req on the same edge ignored
        bus.req = 1;
        tick();
        bus.req = 0;
        chk("j_launch_addr", bus.mem_addr, 16'h0003);
        tick();
        bus.ld_pc = 1; bus.pc_in = 16'h85A1; bus.req = 1;
        tick();
        bus.ld_pc = 0; bus.req = 0;
        $display("jump: pc=%h valid=%b busy=%b", bus.pc, bus.valid, bus.busy);
        chk("jump_pc", bus.pc, 16'h85A1);
        chk("jump_valid", bus.valid, 0);
        chk("jump_busy", bus.busy, 0);
        tick();
        tick();
        chk("jump_drop_valid", bus.valid, 0);
        chk("jump_drop_instr", bus.instr, 16'h1A00);
        chk("jump_idle_addr", bus.mem_addr, 16'h0003);
        bus.req = 1;
        tick();
        bus.req = 0;
        chk("jt_mem_addr", bus.mem_addr, 16'h85A1);
        chk("jt_pc", bus.pc, 16'h85A2);
        tick();
        tick();
        $display("jump target: instr=%h operand=%h valid=%b", bus.instr, bus.operand, bus.valid);
        chk("jt_valid", bus.valid, 1);
        chk("jt_instr", bus.instr, 16'h3C5A);
        chk("jt_operand", bus.operand, 16'h0000);
        chk("jt_two_word", bus.two_word, 0);
        bus.ack = 1;
        tick();
        bus.ack = 0;

        // LDA at 0xFFFF: immediate fetched from wrapped address 0
        bus.ld_pc = 1; bus.pc_in = 16'hFFFF;
        tick();
        bus.ld_pc = 0;
        bus.req = 1;
        tick();
        bus.req = 0;
        chk("wrap_addr0", bus.mem_addr, 16'hFFFF);
        chk("wrap_pc0", bus.pc, 16'h0000);
        tick();
        tick();
        chk("wrap_instr", bus.instr, 16'h2042);
        chk("wrap_addr1", bus.mem_addr, 16'h0000);
        tick();
        tick();
        $display("wrap LDA: instr=%h operand=%h pc=%h valid=%b", bus.instr, bus.operand, bus.pc, bus.valid);
        chk("wrap_valid", bus.valid, 1);
        chk("wrap_operand", bus.operand, 16'h0123);
        chk("wrap_two_word", bus.two_word, 1);
        chk("wrap_pc", bus.pc, 16'h0001);
        bus.ack = 1;
        tick();
        bus.ack = 0;

        // Reset pulse in the middle of WAIT_O (MVI at address 1)
        bus.req = 1;
        tick();
        bus.req = 0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_two_word", bus.two_word, 1);
        #2 rst = 1;
        #1;
        $display("mid-fetch reset: pc=%h busy=%b instr=%h", bus.pc, bus.busy, bus.instr);
        chk_all_zero("midrst");
        #2 rst = 0;
        tick();
        tick();
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_valid", bus.valid, 0);
        chk("post_rst_pc", bus.pc, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
